// File: rtl/cmsdk_apb_timclken_gen.sv
// cmsdk_apb_timclken_gen
// APB-programmable clock-enable generator for the dual timers. Each of the two
// channels is a reload down-counter in the PCLK domain. Every DIVn+1 ticks the
// channel raises its TIMCLKENn for one PCLK cycle.
// Optional feature macro: CLKEN_GEN_EXTIN_EN. When it is defined, the block
// adds an EXTIN port. A channel can then count synchronised EXTIN rising edges
// instead of PCLK cycles.

module cmsdk_apb_timclken_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [11:2] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
`ifdef CLKEN_GEN_EXTIN_EN
  input  logic        EXTIN,
`endif
  output logic        TIMCLKEN1,
  output logic        TIMCLKEN2
);

  localparam logic [9:0] ADDR_CTRL = 10'h000;
  localparam logic [9:0] ADDR_DIV1 = 10'h001;
  localparam logic [9:0] ADDR_DIV2 = 10'h002;
  localparam logic [9:0] ADDR_CNT1 = 10'h003;
  localparam logic [9:0] ADDR_CNT2 = 10'h004;

  logic                 wr_en;
  logic                 rd_en;
  logic                 en1;
  logic                 en2;
  logic                 sync_pending;
  logic [DIV_WIDTH-1:0] div1;
  logic [DIV_WIDTH-1:0] div2;
  logic [DIV_WIDTH-1:0] cnt1;
  logic [DIV_WIDTH-1:0] cnt2;
  logic                 tick1;
  logic                 tick2;
  logic [31:0]          rd_mux;
  logic                 unused_ok;

  // Writes and reads both act on the setup-phase edge, so there are zero wait states.
  assign wr_en = PSEL & PWRITE & ~PENABLE;
  assign rd_en = PSEL & ~PWRITE & ~PENABLE;

  // Not every PWDATA bit maps to a register field.
  assign unused_ok = ^PWDATA;

`ifdef CLKEN_GEN_EXTIN_EN
  logic       src1;
  logic       src2;
  logic [2:0] ext_sync;
  logic       ext_rise;

  // Two-flop synchroniser on EXTIN, plus a delayed copy for edge detection.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) ext_sync <= 3'b000;
    else          ext_sync <= {ext_sync[1:0], EXTIN};
  end

  assign ext_rise = ext_sync[1] & ~ext_sync[2];
  assign tick1    = ~src1 | ext_rise;
  assign tick2    = ~src2 | ext_rise;

  // Select a source for each channel: src=1 counts EXTIN edges instead of PCLK.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      src1 <= 1'b0;
      src2 <= 1'b0;
    end else if (wr_en && PADDR == ADDR_CTRL) begin
      src1 <= PWDATA[3];
      src2 <= PWDATA[4];
    end
  end
`else
  assign tick1 = 1'b1;
  assign tick2 = 1'b1;
`endif

  // Update the CTRL and DIV registers. SYNC is a one-cycle request that clears itself.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      en1          <= 1'b0;
      en2          <= 1'b0;
      sync_pending <= 1'b0;
      div1         <= '0;
      div2         <= '0;
    end else begin
      sync_pending <= 1'b0;
      if (wr_en) begin
        case (PADDR)
          ADDR_CTRL: begin
            en1          <= PWDATA[0];
            en2          <= PWDATA[1];
            sync_pending <= PWDATA[2];
          end
          ADDR_DIV1: div1 <= PWDATA[DIV_WIDTH-1:0];
          ADDR_DIV2: div2 <= PWDATA[DIV_WIDTH-1:0];
          default:   ;
        endcase
      end
    end
  end

  // Channel 1 reload counter. SYNC or a disabled channel keeps the counter preloaded.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt1      <= '0;
      TIMCLKEN1 <= 1'b0;
    end else if (sync_pending || !en1) begin
      cnt1      <= div1;
      TIMCLKEN1 <= 1'b0;
    end else if (tick1) begin
      if (cnt1 == '0) begin
        cnt1      <= div1;
        TIMCLKEN1 <= 1'b1;
      end else begin
        cnt1      <= cnt1 - 1'b1;
        TIMCLKEN1 <= 1'b0;
      end
    end else begin
      TIMCLKEN1 <= 1'b0;
    end
  end

  // Channel 2 reload counter. It uses the same scheme as channel 1.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt2      <= '0;
      TIMCLKEN2 <= 1'b0;
    end else if (sync_pending || !en2) begin
      cnt2      <= div2;
      TIMCLKEN2 <= 1'b0;
    end else if (tick2) begin
      if (cnt2 == '0) begin
        cnt2      <= div2;
        TIMCLKEN2 <= 1'b1;
      end else begin
        cnt2      <= cnt2 - 1'b1;
        TIMCLKEN2 <= 1'b0;
      end
    end else begin
      TIMCLKEN2 <= 1'b0;
    end
  end

  // Read mux. Unmapped addresses read zero, and SYNC always reads back as 0.
  always_comb begin
    rd_mux = '0;
    case (PADDR)
      ADDR_CTRL: begin
        rd_mux[0] = en1;
        rd_mux[1] = en2;
`ifdef CLKEN_GEN_EXTIN_EN
        rd_mux[3] = src1;
        rd_mux[4] = src2;
`endif
      end
      ADDR_DIV1: rd_mux[DIV_WIDTH-1:0] = div1;
      ADDR_DIV2: rd_mux[DIV_WIDTH-1:0] = div2;
      ADDR_CNT1: rd_mux[DIV_WIDTH-1:0] = cnt1;
      ADDR_CNT2: rd_mux[DIV_WIDTH-1:0] = cnt2;
      default:   rd_mux = '0;
    endcase
  end

  // PRDATA is registered. It holds data only after a read setup edge and is zero otherwise.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)   PRDATA <= '0;
    else if (rd_en) PRDATA <= rd_mux;
    else            PRDATA <= '0;
  end

endmodule

// File: tb/tb_cmsdk_apb_timclken_gen.sv
// tb_cmsdk_apb_timclken_gen
// Directed bench for the clock-enable generator. Each step drives an APB access
// or idles, then compares against hand-computed pulse positions.

module tb_cmsdk_apb_timclken_gen;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [11:2] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        TIMCLKEN1;
  logic        TIMCLKEN2;
`ifdef CLKEN_GEN_EXTIN_EN
  logic        EXTIN;
`endif

  int checks   = 0;
  int failures = 0;

  cmsdk_apb_timclken_gen #(.DIV_WIDTH(16)) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
`ifdef CLKEN_GEN_EXTIN_EN
    .EXTIN     (EXTIN),
`endif
    .TIMCLKEN1 (TIMCLKEN1),
    .TIMCLKEN2 (TIMCLKEN2)
  );

  // 100 MHz clock
  always #5 PCLK = ~PCLK;

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // One zero-wait APB transfer: setup edge, then access edge.
  task automatic applyStimulus(input logic wr, input logic [9:0] addr,
                               input logic [31:0] data, output logic [31:0] rdata);
    PSEL    = 1'b1;
    PWRITE  = wr;
    PENABLE = 1'b0;
    PADDR   = addr;
    PWDATA  = data;
    step(1);
    rdata   = PRDATA;
    PENABLE = 1'b1;
    step(1);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  logic [31:0] rd;
  int          pulse_count;

  initial begin
    PRESETn = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
`ifdef CLKEN_GEN_EXTIN_EN
    EXTIN   = 1'b0;
`endif
    step(3);
    checkOutput("rst_en1", {31'b0, TIMCLKEN1}, 32'h0);
    checkOutput("rst_en2", {31'b0, TIMCLKEN2}, 32'h0);
    checkOutput("rst_prdata", PRDATA, 32'h0);
    PRESETn = 1'b1;
    step(1);

    $display("[TB] reset register readback");
    applyStimulus(1'b0, 10'h000, 32'h0, rd); checkOutput("rst_ctrl", rd, 32'h0);
    applyStimulus(1'b0, 10'h001, 32'h0, rd); checkOutput("rst_div1", rd, 32'h0);
    applyStimulus(1'b0, 10'h002, 32'h0, rd); checkOutput("rst_div2", rd, 32'h0);
    applyStimulus(1'b0, 10'h003, 32'h0, rd); checkOutput("rst_cnt1", rd, 32'h0);
    applyStimulus(1'b0, 10'h004, 32'h0, rd); checkOutput("rst_cnt2", rd, 32'h0);
    checkOutput("idle_prdata", PRDATA, 32'h0);

    $display("[TB] DIV1=3 EN1: pulse every 4 cycles");
    applyStimulus(1'b1, 10'h001, 32'd3, rd);
    applyStimulus(1'b1, 10'h000, 32'h1, rd);
    checkOutput("div3_k1", {31'b0, TIMCLKEN1}, 32'h0);
    for (int k = 2; k <= 12; k++) begin
      step(1);
      checkOutput($sformatf("div3_en1_k%0d", k), {31'b0, TIMCLKEN1}, {31'b0, (k % 4) == 0});
      checkOutput($sformatf("div3_en2_k%0d", k), {31'b0, TIMCLKEN2}, 32'h0);
    end
    applyStimulus(1'b1, 10'h000, 32'h0, rd);

    $display("[TB] DIV2=0 EN2: continuous enable");
    applyStimulus(1'b1, 10'h002, 32'd0, rd);
    applyStimulus(1'b1, 10'h000, 32'h2, rd);
    checkOutput("div0_k1", {31'b0, TIMCLKEN2}, 32'h1);
    for (int k = 2; k <= 4; k++) begin
      step(1);
      checkOutput($sformatf("div0_k%0d", k), {31'b0, TIMCLKEN2}, 32'h1);
      checkOutput($sformatf("div0_en1_k%0d", k), {31'b0, TIMCLKEN1}, 32'h0);
    end
    applyStimulus(1'b1, 10'h000, 32'h0, rd);
    checkOutput("div0_off", {31'b0, TIMCLKEN2}, 32'h0);

    $display("[TB] DIV1=4 DIV2=9 then SYNC");
    applyStimulus(1'b1, 10'h001, 32'd4, rd);
    applyStimulus(1'b1, 10'h002, 32'd9, rd);
    applyStimulus(1'b1, 10'h000, 32'h3, rd);
    step(16);
    applyStimulus(1'b1, 10'h000, 32'h7, rd);
    applyStimulus(1'b0, 10'h003, 32'h0, rd);
    checkOutput("sync_cnt1", rd, 32'd4);
    applyStimulus(1'b0, 10'h004, 32'h0, rd);
    checkOutput("sync_cnt2", rd, 32'd7);
    for (int k = 6; k <= 21; k++) begin
      step(1);
      checkOutput($sformatf("sync_en1_k%0d", k), {31'b0, TIMCLKEN1}, {31'b0, ((k - 1) % 5) == 0});
      checkOutput($sformatf("sync_en2_k%0d", k), {31'b0, TIMCLKEN2}, {31'b0, ((k - 1) % 10) == 0});
    end
    applyStimulus(1'b0, 10'h000, 32'h0, rd);
    checkOutput("ctrl_sync_reads0", rd, 32'h3);

    $display("[TB] DIV1 rewritten mid-count");
    applyStimulus(1'b1, 10'h000, 32'h0, rd);
    applyStimulus(1'b1, 10'h001, 32'd7, rd);
    applyStimulus(1'b1, 10'h000, 32'h1, rd);
    step(6);
    checkOutput("div7_k7", {31'b0, TIMCLKEN1}, 32'h0);
    step(1);
    checkOutput("div7_k8", {31'b0, TIMCLKEN1}, 32'h1);
    applyStimulus(1'b1, 10'h001, 32'd1, rd);
    checkOutput("newdiv_k10", {31'b0, TIMCLKEN1}, 32'h0);
    for (int k = 11; k <= 22; k++) begin
      step(1);
      checkOutput($sformatf("newdiv_k%0d", k), {31'b0, TIMCLKEN1},
                  {31'b0, (k == 16) || (k > 16 && (k % 2) == 0)});
    end

    $display("[TB] asynchronous reset mid-period");
    #2;
    PRESETn = 1'b0;
    #1;
    checkOutput("async_rst_en1", {31'b0, TIMCLKEN1}, 32'h0);
    step(2);
    PRESETn = 1'b1;
    step(1);
    applyStimulus(1'b0, 10'h001, 32'h0, rd); checkOutput("async_rst_div1", rd, 32'h0);
    applyStimulus(1'b0, 10'h003, 32'h0, rd); checkOutput("async_rst_cnt1", rd, 32'h0);

    $display("[TB] SRC bits and unmapped address");
    applyStimulus(1'b1, 10'h000, 32'h18, rd);
    applyStimulus(1'b0, 10'h000, 32'h0, rd);
`ifdef CLKEN_GEN_EXTIN_EN
    checkOutput("ctrl_src", rd, 32'h18);
`else
    checkOutput("ctrl_src", rd, 32'h0);
`endif
    applyStimulus(1'b1, 10'h020, 32'hFFFF_FFFF, rd);
    applyStimulus(1'b0, 10'h020, 32'h0, rd); checkOutput("unmapped_rd", rd, 32'h0);
    applyStimulus(1'b0, 10'h002, 32'h0, rd); checkOutput("unmapped_div2", rd, 32'h0);

`ifdef CLKEN_GEN_EXTIN_EN
    $display("[TB] EXTIN-driven channel 1");
    applyStimulus(1'b1, 10'h000, 32'h0, rd);
    applyStimulus(1'b1, 10'h001, 32'd2, rd);
    applyStimulus(1'b1, 10'h000, 32'h9, rd);
    pulse_count = 0;
    for (int p = 0; p < 6; p++) begin
      EXTIN = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        step(1);
        if (TIMCLKEN1) pulse_count++;
        checkOutput($sformatf("extin_p%0d_c%0d", p, c), {31'b0, TIMCLKEN1},
                    {31'b0, (c == 3) && (p == 2 || p == 5)});
      end
      EXTIN = 1'b0;
      for (int c = 0; c < 4; c++) begin
        step(1);
        if (TIMCLKEN1) pulse_count++;
      end
    end
    checkOutput("extin_pulses", pulse_count, 32'd2);
`else
    pulse_count = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
